mips_multicycle_ctrl: RTL and testbench

Multi-cycle main control FSM for the MIPS core. It sequences one instruction through fetch, decode, execute, memory and write-back over several cycles, and drives the datapath mux selects, register/memory enables and the 4-bit `alu_op` consumed by the ALU control decoder. It waits on a single memory-ready handshake and traps on illegal opcodes or memory timeouts.

---
 rtl/mips_multicycle_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/write-back,
// drives datapath selects and alu_op, and traps on illegal opcodes or memory timeouts.
module mips_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic [3:0] alu_op,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;

  localparam logic             WD_EN  = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WD_MAX = CNT_W'(MEM_TIMEOUT);

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  typedef enum logic [STATE_W-1:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_I_EXEC    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_TRAP      = 4'd13
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic             wd_expired;
  logic             in_mem_state;

  assign wd_expired   = WD_EN && (cnt_q == WD_MAX);
  assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                        (state_q == S_MEM_WRITE);

  // Next-state, sticky flags and control outputs decoded from the current state
  always_comb begin
    state_d       = state_q;
    illegal_d     = illegal_q;
    bus_err_d     = bus_err_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    imm_zext      = 1'b0;
    alu_op        = 4'b0000;

    case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (wd_expired) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end
      end

      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:                      state_d = S_R_EXEC;
          OP_LW, OP_SW:                  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                state_d = S_BRANCH;
          OP_J:                          state_d = S_JUMP;
          OP_ADDI, OP_ADDIU, OP_ANDI,
          OP_ORI, OP_XORI, OP_LUI:       state_d = S_I_EXEC;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_TRAP;
          end
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end

      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (wd_expired) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (wd_expired) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end
      end

      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 4'b1000;
        state_d   = S_R_WB;
      end

      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end

      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode)
          OP_ADDI, OP_ADDIU: alu_op = 4'b0001;
          OP_ANDI:           alu_op = 4'b0010;
          OP_ORI:            alu_op = 4'b0011;
          OP_XORI:           alu_op = 4'b0101;
          OP_LUI:            alu_op = 4'b0111;
          default:           alu_op = 4'b0000;
        endcase
        imm_zext = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
        state_d  = S_I_WB;
      end

      S_I_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = (opcode == OP_BNE) ? 4'b0110 : 4'b0100;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        state_d       = S_FETCH;
      end

      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        state_d  = S_FETCH;
      end

      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    // Wait counter restarts on every state change and saturates while waiting
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (in_mem_state && !mem_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign state   = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: the driver queues a hand-written expected
// output vector for every cycle it drives, and a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [3:0] alu_op;
    logic       illegal;
    logic       bus_err;
    logic [3:0] state;
  } out_t;

  typedef struct {
    string name;
    out_t  val;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, imm_zext, illegal, bus_err;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_op, state;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_zext(imm_zext),
    .alu_op(alu_op), .illegal(illegal), .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  // Expected output vectors, one per state, written straight from the state table
  function automatic out_t e_zero();
    out_t o = '0;
    return o;
  endfunction
  function automatic out_t e_fetch(input logic rdy);
    out_t o = '0;
    o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy;
    o.state = 4'd1;
    return o;
  endfunction
  function automatic out_t e_decode();
    out_t o = '0;
    o.alu_src_b = 2'b11; o.state = 4'd2;
    return o;
  endfunction
  function automatic out_t e_mem_addr();
    out_t o = '0;
    o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.state = 4'd3;
    return o;
  endfunction
  function automatic out_t e_mem_read();
    out_t o = '0;
    o.mem_read = 1'b1; o.iord = 1'b1; o.state = 4'd4;
    return o;
  endfunction
  function automatic out_t e_mem_wb();
    out_t o = '0;
    o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.state = 4'd5;
    return o;
  endfunction
  function automatic out_t e_mem_write();
    out_t o = '0;
    o.mem_write = 1'b1; o.iord = 1'b1; o.state = 4'd6;
    return o;
  endfunction
  function automatic out_t e_r_exec();
    out_t o = '0;
    o.alu_src_a = 1'b1; o.alu_op = 4'b1000; o.state = 4'd7;
    return o;
  endfunction
  function automatic out_t e_r_wb();
    out_t o = '0;
    o.reg_write = 1'b1; o.reg_dst = 1'b1; o.state = 4'd8;
    return o;
  endfunction
  function automatic out_t e_i_exec(input logic [3:0] aop, input logic zx);
    out_t o = '0;
    o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = aop; o.imm_zext = zx;
    o.state = 4'd9;
    return o;
  endfunction
  function automatic out_t e_i_wb();
    out_t o = '0;
    o.reg_write = 1'b1; o.state = 4'd10;
    return o;
  endfunction
  function automatic out_t e_branch(input logic [3:0] aop);
    out_t o = '0;
    o.alu_src_a = 1'b1; o.alu_op = aop; o.pc_write_cond = 1'b1; o.pc_src = 2'b01;
    o.state = 4'd11;
    return o;
  endfunction
  function automatic out_t e_jump();
    out_t o = '0;
    o.pc_write = 1'b1; o.pc_src = 2'b10; o.state = 4'd12;
    return o;
  endfunction
  function automatic out_t e_trap(input logic ill, input logic berr);
    out_t o = '0;
    o.illegal = ill; o.bus_err = berr; o.state = 4'd13;
    return o;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected during that cycle
  task automatic step(input string nm, input out_t ex, input logic [5:0] op,
                      input logic rdy, input logic rn);
    sb_t e;
    rst_n     = rn;
    opcode    = op;
    mem_ready = rdy;
    e.name    = nm;
    e.val     = ex;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      sb_t  e;
      out_t a;
      e = sb_q.pop_front();
      a.pc_write = pc_write;   a.pc_write_cond = pc_write_cond; a.pc_src = pc_src;
      a.iord = iord;           a.mem_read = mem_read;           a.mem_write = mem_write;
      a.ir_write = ir_write;   a.reg_dst = reg_dst;             a.mem_to_reg = mem_to_reg;
      a.reg_write = reg_write; a.alu_src_a = alu_src_a;         a.alu_src_b = alu_src_b;
      a.imm_zext = imm_zext;   a.alu_op = alu_op;               a.illegal = illegal;
      a.bus_err = bus_err;     a.state = state;
      n_cmp++;
      if (a !== e.val) begin
        n_err++;
        $display("FAIL %s: got state=%0d vec=%h, expected state=%0d vec=%h",
                 e.name, a.state, a, e.val.state, e.val);
      end
    end
  end

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic [5:0] i_ops [6] = '{6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001111};
  logic [3:0] i_aop [6] = '{4'b0001, 4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0111};
  logic       i_zx  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0; opcode = OP_R; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    step("reset_hold", e_zero(), OP_R, 1'b1, 1'b0);
    step("reset_release", e_zero(), OP_R, 1'b1, 1'b1);

    // R-type, zero wait: 1,2,7,8
    step("r_fetch", e_fetch(1'b1), OP_R, 1'b1, 1'b1);
    step("r_decode", e_decode(), OP_R, 1'b1, 1'b1);
    step("r_exec", e_r_exec(), OP_R, 1'b1, 1'b1);
    step("r_wb", e_r_wb(), OP_R, 1'b1, 1'b1);

    // lw with two wait cycles on the data read: 1,2,3,4,4,4,5
    step("lw_fetch", e_fetch(1'b1), OP_LW, 1'b1, 1'b1);
    step("lw_decode", e_decode(), OP_LW, 1'b0, 1'b1);
    step("lw_addr", e_mem_addr(), OP_LW, 1'b0, 1'b1);
    step("lw_read_w1", e_mem_read(), OP_LW, 1'b0, 1'b1);
    step("lw_read_w2", e_mem_read(), OP_LW, 1'b0, 1'b1);
    step("lw_read_rdy", e_mem_read(), OP_LW, 1'b1, 1'b1);
    step("lw_wb", e_mem_wb(), OP_LW, 1'b0, 1'b1);

    // sw, zero wait: 1,2,3,6
    step("sw_fetch", e_fetch(1'b1), OP_SW, 1'b1, 1'b1);
    step("sw_decode", e_decode(), OP_SW, 1'b1, 1'b1);
    step("sw_addr", e_mem_addr(), OP_SW, 1'b1, 1'b1);
    step("sw_write", e_mem_write(), OP_SW, 1'b1, 1'b1);

    for (int i = 0; i < 6; i++) begin
      step("i_fetch", e_fetch(1'b1), i_ops[i], 1'b1, 1'b1);
      step("i_decode", e_decode(), i_ops[i], 1'b1, 1'b1);
      step("i_exec", e_i_exec(i_aop[i], i_zx[i]), i_ops[i], 1'b1, 1'b1);
      step("i_wb", e_i_wb(), i_ops[i], 1'b1, 1'b1);
    end

    step("beq_fetch", e_fetch(1'b1), OP_BEQ, 1'b1, 1'b1);
    step("beq_decode", e_decode(), OP_BEQ, 1'b1, 1'b1);
    step("beq_branch", e_branch(4'b0100), OP_BEQ, 1'b1, 1'b1);
    step("bne_fetch", e_fetch(1'b1), OP_BNE, 1'b1, 1'b1);
    step("bne_decode", e_decode(), OP_BNE, 1'b1, 1'b1);
    step("bne_branch", e_branch(4'b0110), OP_BNE, 1'b1, 1'b1);
    step("j_fetch", e_fetch(1'b1), OP_J, 1'b1, 1'b1);
    step("j_decode", e_decode(), OP_J, 1'b1, 1'b1);
    step("j_jump", e_jump(), OP_J, 1'b1, 1'b1);

    // Ready arrives exactly when the wait count hits the limit: ready wins
    for (int i = 0; i < 4; i++) step("wd_edge_wait", e_fetch(1'b0), OP_J, 1'b0, 1'b1);
    step("wd_edge_ready", e_fetch(1'b1), OP_J, 1'b1, 1'b1);
    step("wd_edge_decode", e_decode(), OP_J, 1'b0, 1'b1);
    step("wd_edge_jump", e_jump(), OP_J, 1'b0, 1'b1);

    // Reset mid-instruction drops the memory strobe at once
    step("mid_fetch", e_fetch(1'b1), OP_LW, 1'b1, 1'b1);
    step("mid_decode", e_decode(), OP_LW, 1'b0, 1'b1);
    step("mid_addr", e_mem_addr(), OP_LW, 1'b0, 1'b1);
    step("mid_read", e_mem_read(), OP_LW, 1'b0, 1'b1);
    step("mid_reset", e_zero(), OP_LW, 1'b0, 1'b0);
    step("mid_release", e_zero(), OP_LW, 1'b0, 1'b1);

    // Fetch timeout: counts 0..4 without ready, then TRAP with bus_err
    for (int i = 0; i < 5; i++) step("wd_to_wait", e_fetch(1'b0), OP_R, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("wd_to_trap", e_trap(1'b0, 1'b1), OP_R, 1'(i), 1'b1);
    step("wd_to_reset", e_zero(), OP_R, 1'b0, 1'b0);
    step("wd_to_release", e_zero(), OP_R, 1'b1, 1'b1);

    // Illegal opcode: sticky trap held for 100 cycles, cleared only by reset
    step("ill_fetch", e_fetch(1'b1), OP_BAD, 1'b1, 1'b1);
    step("ill_decode", e_decode(), OP_BAD, 1'b1, 1'b1);
    for (int i = 0; i < 100; i++) step("ill_trap", e_trap(1'b1, 1'b0), OP_R, 1'(i), 1'b1);
    step("ill_reset", e_zero(), OP_R, 1'b1, 1'b0);
    step("ill_release", e_zero(), OP_R, 1'b1, 1'b1);
    step("post_fetch", e_fetch(1'b1), OP_R, 1'b1, 1'b1);
    step("post_decode", e_decode(), OP_R, 1'b1, 1'b1);

    for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", sb_q.size());
    end
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
